// File: rtl/fetch_bundle_tx.sv
// fetch_bundle_tx: packs one I-cache block response and its branch prediction
// into a fetch bundle. The bundle is held in a 2-entry skid FIFO that feeds the
// backend ingress. Stale-epoch responses are discarded and counted, and a flush
// empties the FIFO.
module fetch_bundle_tx #(
    parameter int unsigned IPF           = 4,
    parameter int unsigned ILEN          = 32,
    parameter int unsigned PLEN          = 32,
    parameter int unsigned IFU_INF_DEPTH = 4,
    parameter int unsigned FTQ_W         = (IFU_INF_DEPTH >= 2) ? $clog2(IFU_INF_DEPTH) : 1,
    parameter int unsigned SLOT_W        = $clog2(IPF)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [2:0]              cur_epoch_i,
    input  logic                    line_valid_i,
    output logic                    line_ready_o,
    input  logic [IPF*ILEN-1:0]     line_data_i,
    input  logic [PLEN-1:0]         line_pc_i,
    input  logic [FTQ_W-1:0]        line_ftq_id_i,
    input  logic [2:0]              line_epoch_i,
    input  logic                    pred_taken_i,
    input  logic [SLOT_W-1:0]       pred_slot_i,
    input  logic [PLEN-1:0]         pred_target_i,
    output logic                    fe_valid_o,
    input  logic                    fe_ready_i,
    output logic [IPF*ILEN-1:0]     fe_instrs_o,
    output logic [PLEN-1:0]         fe_pc_o,
    output logic [IPF-1:0]          fe_slot_valid_o,
    output logic [IPF*PLEN-1:0]     fe_pred_npc_o,
    output logic [IPF*FTQ_W-1:0]    fe_ftq_id_o,
    output logic [IPF*3-1:0]        fe_fetch_epoch_o,
    output logic [31:0]             drop_cnt_o
);

    // FIFO storage: only per-bundle values are kept, per-slot replication is done at the output
    logic [IPF*ILEN-1:0]  instrs_q [2];
    logic [PLEN-1:0]      pc_q     [2];
    logic [IPF-1:0]       mask_q   [2];
    logic [IPF*PLEN-1:0]  npc_q    [2];
    logic [FTQ_W-1:0]     ftq_q    [2];
    logic [2:0]           epoch_q  [2];

    logic [1:0]  count_q, count_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] drop_q, drop_d;

    logic                accept, stale, push, pop;
    logic [SLOT_W-1:0]   off;
    logic [PLEN-1:0]     base;
    logic                eff;
    logic [IPF-1:0]      slot_valid;
    logic [IPF*PLEN-1:0] pred_npc;

    assign line_ready_o = (count_q < 2'd2);
    assign fe_valid_o   = (count_q != 2'd0);
    assign accept       = line_valid_i & line_ready_o & ~flush_i;
    assign stale        = accept & (line_epoch_i != cur_epoch_i);
    assign push         = accept & (line_epoch_i == cur_epoch_i);
    assign pop          = fe_valid_o & fe_ready_i & ~flush_i;

    // Bundle packing: slot mask and per-slot predicted next PC from the fetch PC and prediction
    always_comb begin
        slot_valid = '0;
        pred_npc   = '0;
        off        = line_pc_i[SLOT_W+1:2];
        base       = line_pc_i;
        base[SLOT_W+1:0] = '0;
        // A taken branch before the fetch entry point is not on this fetch path
        eff        = pred_taken_i & (pred_slot_i >= off);
        for (int unsigned i = 0; i < IPF; i++) begin
            slot_valid[i] = (SLOT_W'(i) >= off) & (~eff | (SLOT_W'(i) <= pred_slot_i));
            pred_npc[i*PLEN +: PLEN] = base + PLEN'(4 * (i + 1));
            if (eff && (SLOT_W'(i) == pred_slot_i)) begin
                pred_npc[i*PLEN +: PLEN] = pred_target_i;
            end
        end
    end

    // FIFO pointer, occupancy and drop-counter next state; flush overrides push and pop
    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        drop_d  = drop_q;
        if (flush_i) begin
            count_d = 2'd0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end else begin
            if (stale) drop_d = drop_q + 32'd1;
            if (push)  wr_d   = ~wr_q;
            if (pop)   rd_d   = ~rd_q;
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            drop_q  <= '0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            drop_q  <= drop_d;
        end
    end

    // Payload storage written on push
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned e = 0; e < 2; e++) begin
                instrs_q[e] <= '0;
                pc_q[e]     <= '0;
                mask_q[e]   <= '0;
                npc_q[e]    <= '0;
                ftq_q[e]    <= '0;
                epoch_q[e]  <= '0;
            end
        end else if (push) begin
            instrs_q[wr_q] <= line_data_i;
            pc_q[wr_q]     <= base;
            mask_q[wr_q]   <= slot_valid;
            npc_q[wr_q]    <= pred_npc;
            ftq_q[wr_q]    <= line_ftq_id_i;
            epoch_q[wr_q]  <= line_epoch_i;
        end
    end

    assign fe_instrs_o      = instrs_q[rd_q];
    assign fe_pc_o          = pc_q[rd_q];
    assign fe_slot_valid_o  = mask_q[rd_q];
    assign fe_pred_npc_o    = npc_q[rd_q];
    assign fe_ftq_id_o      = {IPF{ftq_q[rd_q]}};
    assign fe_fetch_epoch_o = {IPF{epoch_q[rd_q]}};
    assign drop_cnt_o       = drop_q;

endmodule

// File: tb/tb_fetch_bundle_tx.sv
// Testbench for fetch_bundle_tx (IPF=4, ILEN=32, PLEN=32, 2-bit FTQ id): directed
// scenarios plus randomized traffic, compared against a queue-based bundle model.
module tb_fetch_bundle_tx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [2:0]   cur_ep;
    logic         line_valid;
    logic         line_ready;
    logic [127:0] line_data;
    logic [31:0]  line_pc;
    logic [1:0]   line_ftq;
    logic [2:0]   line_ep;
    logic         pred_taken;
    logic [1:0]   pred_slot;
    logic [31:0]  pred_target;
    logic         fe_valid;
    logic         fe_ready;
    logic [127:0] fe_instrs;
    logic [31:0]  fe_pc;
    logic [3:0]   fe_mask;
    logic [127:0] fe_npc;
    logic [7:0]   fe_ftq;
    logic [11:0]  fe_ep;
    logic [31:0]  drop_cnt;

    always #5 clk = ~clk;

    fetch_bundle_tx #(
        .IPF(4), .ILEN(32), .PLEN(32), .IFU_INF_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .cur_epoch_i(cur_ep),
        .line_valid_i(line_valid), .line_ready_o(line_ready), .line_data_i(line_data),
        .line_pc_i(line_pc), .line_ftq_id_i(line_ftq), .line_epoch_i(line_ep),
        .pred_taken_i(pred_taken), .pred_slot_i(pred_slot), .pred_target_i(pred_target),
        .fe_valid_o(fe_valid), .fe_ready_i(fe_ready), .fe_instrs_o(fe_instrs),
        .fe_pc_o(fe_pc), .fe_slot_valid_o(fe_mask), .fe_pred_npc_o(fe_npc),
        .fe_ftq_id_o(fe_ftq), .fe_fetch_epoch_o(fe_ep), .drop_cnt_o(drop_cnt)
    );

    typedef struct {
        logic [127:0] instrs;
        logic [31:0]  pc;
        logic [3:0]   mask;
        logic [127:0] npc;
        logic [1:0]   ftq;
        logic [2:0]   ep;
    } bundle_t;

    bundle_t     exp_q[$];
    logic [31:0] exp_drop;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference packing: reason in terms of each slot's own PC relative to the fetch PC
    function automatic bundle_t pack(input logic [127:0] d, input logic [31:0] pc,
                                     input logic [1:0] ftq, input logic [2:0] ep,
                                     input logic tk, input logic [1:0] sl, input logic [31:0] tgt);
        bundle_t     b;
        logic [31:0] blk;
        logic [31:0] br_pc;
        logic [31:0] spc;
        logic        taken;
        blk   = pc & 32'hFFFF_FFF0;
        br_pc = blk + 32'(sl) * 4;
        taken = tk && (br_pc >= pc);
        b.instrs = d;
        b.pc     = blk;
        b.ftq    = ftq;
        b.ep     = ep;
        for (int i = 0; i < 4; i++) begin
            spc = blk + 32'(i) * 4;
            b.mask[i] = (spc >= pc) && (!taken || spc <= br_pc);
            b.npc[i*32 +: 32] = (taken && i == int'(sl)) ? tgt : spc + 32'd4;
        end
        return b;
    endfunction

    task automatic check_outputs();
        check("line_ready", 128'(line_ready), 128'(exp_q.size() < 2));
        check("fe_valid", 128'(fe_valid), 128'(exp_q.size() != 0));
        check("drop_cnt", 128'(drop_cnt), 128'(exp_drop));
        if (exp_q.size() != 0) begin
            check("instrs", fe_instrs, exp_q[0].instrs);
            check("fe_pc", 128'(fe_pc), 128'(exp_q[0].pc));
            check("mask", 128'(fe_mask), 128'(exp_q[0].mask));
            check("pred_npc", fe_npc, exp_q[0].npc);
            check("ftq_id", 128'(fe_ftq), 128'({4{exp_q[0].ftq}}));
            check("epoch", 128'(fe_ep), 128'({4{exp_q[0].ep}}));
        end
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge
    task automatic step(input logic v, input logic [31:0] pc, input logic [2:0] lep,
                        input logic tk, input logic [1:0] sl, input logic [31:0] tgt,
                        input logic rdy, input logic fl);
        bundle_t b;
        logic    acc;
        logic    pop;
        line_valid  = v;
        line_pc     = pc;
        line_ep     = lep;
        pred_taken  = tk;
        pred_slot   = sl;
        pred_target = tgt;
        fe_ready    = rdy;
        flush       = fl;
        line_data   = {$urandom, $urandom, $urandom, $urandom};
        line_ftq    = 2'($urandom);
        @(posedge clk);
        acc = v && (exp_q.size() < 2) && !fl;
        pop = rdy && (exp_q.size() != 0);
        b   = pack(line_data, pc, line_ftq, lep, tk, sl, tgt);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                if (lep != cur_ep) exp_drop = exp_drop + 32'd1;
                else exp_q.push_back(b);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; cur_ep = 3'd0; line_valid = 1'b0; line_data = '0;
        line_pc = '0; line_ftq = '0; line_ep = '0; pred_taken = 1'b0; pred_slot = '0;
        pred_target = '0; fe_ready = 1'b0;
        exp_drop = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_fe_pc", 128'(fe_pc), 128'(0));
        check("rst_mask", 128'(fe_mask), 128'(0));
        check_outputs();

        // Full block, no prediction
        step(1, 32'h8000_0000, 3'd0, 0, 2'd0, 32'h0, 1, 0);
        check("t1_mask", 128'(fe_mask), 128'(4'b1111));
        check("t1_npc3", 128'(fe_npc[127:96]), 128'(32'h8000_0010));
        check("t1_npc0", 128'(fe_npc[31:0]), 128'(32'h8000_0004));
        step(0, 32'h0, 3'd0, 0, 2'd0, 32'h0, 1, 0);

        // Mid-block entry with taken branch, then taken branch before the entry point
        step(1, 32'h8000_0008, 3'd0, 1, 2'd2, 32'h8000_0100, 1, 0);
        check("t2_mask", 128'(fe_mask), 128'(4'b0100));
        check("t2_npc2", 128'(fe_npc[95:64]), 128'(32'h8000_0100));
        step(1, 32'h8000_0008, 3'd0, 1, 2'd1, 32'h8000_0100, 1, 0);
        check("t2b_mask", 128'(fe_mask), 128'(4'b1100));
        check("t2b_npc3", 128'(fe_npc[127:96]), 128'(32'h8000_0010));
        step(0, 32'h0, 3'd0, 0, 2'd0, 32'h0, 1, 0);

        // Back-pressure: three lines with ingress stalled, then release
        step(1, 32'h0000_1000, 3'd0, 0, 2'd0, 32'h0, 0, 0);
        step(1, 32'h0000_1010, 3'd0, 0, 2'd0, 32'h0, 0, 0);
        check("t3_full_ready", 128'(line_ready), 128'(0));
        step(1, 32'h0000_1020, 3'd0, 0, 2'd0, 32'h0, 0, 0);
        step(1, 32'h0000_1020, 3'd0, 0, 2'd0, 32'h0, 1, 0);
        step(1, 32'h0000_1020, 3'd0, 0, 2'd0, 32'h0, 1, 0);
        repeat (3) step(0, 32'h0, 3'd0, 0, 2'd0, 32'h0, 1, 0);

        // Stale epoch
        cur_ep = 3'd3;
        step(1, 32'h8000_0000, 3'd2, 0, 2'd0, 32'h0, 1, 0);
        check("t4_valid", 128'(fe_valid), 128'(0));
        check("t4_drop", 128'(drop_cnt), 128'(1));

        // Flush with full FIFO and a valid line
        step(1, 32'h0000_2000, 3'd3, 0, 2'd0, 32'h0, 0, 0);
        step(1, 32'h0000_2010, 3'd3, 0, 2'd0, 32'h0, 0, 0);
        step(1, 32'h0000_2020, 3'd3, 0, 2'd0, 32'h0, 1, 1);
        check("t5_valid", 128'(fe_valid), 128'(0));
        check("t5_ready", 128'(line_ready), 128'(1));
        check("t5_drop", 128'(drop_cnt), 128'(1));
        step(0, 32'h0, 3'd3, 0, 2'd0, 32'h0, 1, 0);

        // Address wrap at the top of the space
        step(1, 32'hFFFF_FFF0, 3'd3, 0, 2'd0, 32'h0, 0, 0);
        check("t6_npc3_wrap", 128'(fe_npc[127:96]), 128'(32'h0));
        step(1, 32'h0000_3000, 3'd3, 0, 2'd0, 32'h0, 0, 0);

        // Asynchronous reset mid-stall
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 128'(fe_valid), 128'(0));
        check("t6_rst_ready", 128'(line_ready), 128'(1));
        check("t6_rst_drop", 128'(drop_cnt), 128'(0));
        exp_q.delete();
        exp_drop = '0;
        line_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc;
            logic [2:0]  lep;
            if ($urandom_range(0, 15) == 0) cur_ep = 3'($urandom);
            pc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            pc  = pc & 32'hFFFF_FFFC;
            lep = ($urandom_range(0, 3) == 0) ? 3'($urandom) : cur_ep;
            step($urandom_range(0, 3) != 0, pc, lep, 1'($urandom), 2'($urandom),
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
